// File: rtl/cbc_stream_if.sv
// Stream-side bundle of cbc_stream: message control, input chunk stream,
// output chunk stream and status. The DUT uses the slave modport.
interface cbc_stream_if #(
  parameter int N = 1,
  parameter int M = 4
);
  localparam int W  = 8 * N;
  localparam int CW = $clog2(M + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds data/last stable while valid && !ready; ready never
  // depends combinationally on valid.
  logic          start;
  logic          enc_dec;
  logic [W-1:0]  key;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] chunk_count;
  logic [1:0]    dbg_state;

  modport slave (
    input  start, enc_dec, key, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, chunk_count,
           dbg_state
  );

  modport master (
    output start, enc_dec, key, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done, chunk_count,
           dbg_state
  );
endinterface

// File: rtl/cbc_stream.sv
// Chunk-serial XOR-chained CBC transform with a one-deep output register.
// chunk 0 = d0 ^ key, chunk i = d_i ^ c_(i-1), in either direction.
module cbc_stream #(
  parameter int N = 1,
  parameter int M = 4
) (
  input  logic        clk,
  input  logic        rst,
  cbc_stream_if.slave bus
);
  localparam int W  = 8 * N;
  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_enc_dec;
  logic [W-1:0]  r_chain;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_done;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic          w_in_hs;
  logic          w_out_hs;
  logic [W-1:0]  w_xor;
  logic          w_last;

  // Ready looks only at the output register and out_ready, never at in_valid.
  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
  assign w_in_hs    = bus.in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && bus.out_ready;
  assign w_xor      = bus.in_data ^ r_chain;
  assign w_last     = bus.in_last || (r_count == CW'(M - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_enc_dec   <= 1'b0;
      r_chain     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_enc_dec <= bus.enc_dec;
            r_chain   <= bus.key;
            r_count   <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_in_hs) begin
            r_out_data  <= w_xor;
            // Encrypt chains on the new ciphertext, decrypt on the incoming one.
            r_chain     <= r_enc_dec ? bus.in_data : w_xor;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
            r_count     <= r_count + 1'b1;
            if (w_last) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (w_out_hs) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_last    = r_out_last;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.chunk_count = r_count;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_cbc_stream.sv
// Bench for cbc_stream: two instances (N=1,M=2 and N=2,M=4) share one driver,
// a CBC scoreboard and a per-cycle compare process through a selected view.
module tb_cbc_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cbc_stream_if #(.N(1), .M(2)) if0 ();
  cbc_stream_if #(.N(2), .M(4)) if1 ();

  cbc_stream #(.N(1), .M(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  cbc_stream #(.N(2), .M(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // shared drive variables; sel picks the active instance
  logic        sel = 1'b0;
  logic        d_start = 1'b0;
  logic        d_enc_dec = 1'b0;
  logic [15:0] d_key = '0;
  logic        d_in_valid = 1'b0;
  logic [15:0] d_in_data = '0;
  logic        d_in_last = 1'b0;
  logic        d_out_ready;
  int          rdy_mode = 0;
  logic [3:0]  rdy_pat = 4'b1001;

  assign if0.start     = d_start && !sel;
  assign if0.enc_dec   = d_enc_dec;
  assign if0.key       = d_key[7:0];
  assign if0.in_valid  = d_in_valid && !sel;
  assign if0.in_data   = d_in_data[7:0];
  assign if0.in_last   = d_in_last;
  assign if0.out_ready = d_out_ready;
  assign if1.start     = d_start && sel;
  assign if1.enc_dec   = d_enc_dec;
  assign if1.key       = d_key;
  assign if1.in_valid  = d_in_valid && sel;
  assign if1.in_data   = d_in_data;
  assign if1.in_last   = d_in_last;
  assign if1.out_ready = d_out_ready;

  logic        v_in_ready, v_out_valid, v_out_last, v_busy, v_done;
  logic [15:0] v_out_data;
  logic [2:0]  v_count;
  assign v_in_ready  = sel ? if1.in_ready  : if0.in_ready;
  assign v_out_valid = sel ? if1.out_valid : if0.out_valid;
  assign v_out_last  = sel ? if1.out_last  : if0.out_last;
  assign v_busy      = sel ? if1.busy      : if0.busy;
  assign v_done      = sel ? if1.done      : if0.done;
  assign v_out_data  = sel ? if1.out_data  : {8'h00, if0.out_data};
  assign v_count     = sel ? if1.chunk_count : {1'b0, if0.chunk_count};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // consumer: out_ready always high, or the repeating 1,0,0,1 stall pattern
  initial begin
    int cyc = 0;
    d_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      d_out_ready = (rdy_mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
    end
  end

  // scoreboard: {last, data} expected per output handshake
  logic [16:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] msg_d[4];
  logic [15:0] lit[4];

  logic        p_stall = 1'b0;
  logic        p_fin = 1'b0;
  logic [15:0] p_data = '0;
  logic        p_last = 1'b0;

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      exp_q.delete();
      p_stall = 1'b0;
      p_fin   = 1'b0;
    end else begin
      chk("done_timing", v_done, p_fin);
      if (v_done) chk("busy_at_done", v_busy, 1'b0);
      if (p_stall) begin
        chk("stall_valid", v_out_valid, 1'b1);
        chk("stall_data", v_out_data, p_data);
        chk("stall_last", v_out_last, p_last);
      end
      if (v_out_valid && !d_out_ready) chk("stall_in_ready", v_in_ready, 1'b0);
      p_fin = 1'b0;
      if (v_out_valid && d_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", v_out_data, e[15:0]);
          chk("out_last", v_out_last, e[16]);
        end
        got_q.push_back(v_out_data);
        p_fin = v_out_last;
      end
      p_stall = v_out_valid && !d_out_ready;
      p_data  = v_out_data;
      p_last  = v_out_last;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_in_ready", v_in_ready, 1'b0);
    chk("rst_out_valid", v_out_valid, 1'b0);
    chk("rst_out_last", v_out_last, 1'b0);
    chk("rst_out_data", v_out_data, 16'h0);
    chk("rst_busy", v_busy, 1'b0);
    chk("rst_done", v_done, 1'b0);
    chk("rst_count", v_count, 3'd0);
  endtask

  // Runs one message from msg_d. Called at posedge+#1.
  // abort_at > 0 stops after that many accepted chunks without waiting for done.
  // hold keeps in_valid high with junk after the message to show it is not consumed.
  task automatic run_msg(input int n, input logic [15:0] key, input logic ed,
                         input bit use_last, input int abort_at, input bit hold);
    logic [15:0] chain, o, mask;
    int mmax, sent, guard, lim;
    bit first, seen;
    mmax  = sel ? 4 : 2;
    mask  = sel ? 16'hFFFF : 16'h00FF;
    chain = key & mask;
    lim   = (abort_at > 0) ? abort_at : n;
    got_q.delete();
    d_start = 1'b1; d_key = key; d_enc_dec = ed;
    @(posedge clk); #1;
    // later key/direction changes must not matter
    d_start = 1'b0; d_key = ~key; d_enc_dec = ~ed;
    d_in_valid = 1'b1; d_in_data = msg_d[0]; d_in_last = use_last && (n == 1);
    sent = 0; guard = 0; first = 1'b1;
    while (sent < lim && guard < 200) begin
      @(negedge clk);
      guard++;
      if (first) begin
        chk("busy_after_start", v_busy, 1'b1);
        chk("in_ready_after_start", v_in_ready, 1'b1);
        first = 1'b0;
      end
      if (v_in_ready) begin
        o = (msg_d[sent] ^ chain) & mask;
        chain = ed ? (msg_d[sent] & mask) : o;
        exp_q.push_back({((use_last && sent == n - 1) || sent == mmax - 1), o});
        sent++;
      end
      @(posedge clk); #1;
      if (sent < n) begin
        d_in_data = msg_d[sent]; d_in_last = use_last && (sent == n - 1);
      end else if (hold) begin
        d_in_data = 16'h0055; d_in_last = 1'b0;
      end else begin
        d_in_valid = 1'b0; d_in_last = 1'b0;
      end
    end
    if (guard >= 200) chk("input_timeout", 32'd1, 32'd0);
    if (abort_at > 0) begin
      d_in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    chk("in_ready_after_last", v_in_ready, 1'b0);
    chk("chunk_count_final", v_count, sent);
    seen = v_done;
    guard = 0;
    while (!seen && guard < 50) begin
      @(negedge clk);
      guard++;
      seen = v_done;
    end
    if (!seen) chk("done_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_lits(input int n, input string nm);
    chk({nm, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk(nm, got_q[i], lit[i]);
  endtask

  initial begin
    // reset state of both instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #0 chk_reset_vals();
    sel = 1'b1; #0 chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    sel = 1'b0;
    @(posedge clk); #1;

    // N=1, M=2: zero message
    msg_d[0] = 16'h00; msg_d[1] = 16'h00;
    lit[0] = 16'hE7; lit[1] = 16'hE7;
    run_msg(2, 16'h00E7, 1'b0, 1'b1, 0, 1'b0);
    chk_lits(2, "zero_msg");

    // forced end at M with in_last never set, junk held on the input
    msg_d[0] = 16'h01; msg_d[1] = 16'h02;
    lit[0] = 16'h3D; lit[1] = 16'h3F;
    run_msg(2, 16'h003C, 1'b0, 1'b0, 0, 1'b1);
    chk_lits(2, "forced_end");
    run_msg(2, 16'h003C, 1'b0, 1'b0, 0, 1'b1);
    chk_lits(2, "forced_restart");

    // N=2, M=4
    sel = 1'b1;
    @(posedge clk); #1;
    msg_d[0] = 16'hFF54; msg_d[1] = 16'h1123; msg_d[2] = 16'hA259; msg_d[3] = 16'h8BCD;
    lit[0] = 16'hF5AF; lit[1] = 16'hE48C; lit[2] = 16'h46D5; lit[3] = 16'hCD18;
    run_msg(4, 16'h0AFB, 1'b0, 1'b1, 0, 1'b0);
    chk_lits(4, "enc4");

    msg_d[0] = 16'hDFDB; msg_d[1] = 16'h5670; msg_d[2] = 16'h1317; msg_d[3] = 16'h1234;
    lit[0] = 16'hCDEF; lit[1] = 16'h89AB; lit[2] = 16'h4567; lit[3] = 16'h0123;
    run_msg(4, 16'h1234, 1'b1, 1'b1, 0, 1'b0);
    chk_lits(4, "dec4");

    // backpressure on the encrypt stream
    msg_d[0] = 16'hFF54; msg_d[1] = 16'h1123; msg_d[2] = 16'hA259; msg_d[3] = 16'h8BCD;
    lit[0] = 16'hF5AF; lit[1] = 16'hE48C; lit[2] = 16'h46D5; lit[3] = 16'hCD18;
    rdy_mode = 1;
    run_msg(4, 16'h0AFB, 1'b0, 1'b1, 0, 1'b0);
    chk_lits(4, "enc4_bp");
    rdy_mode = 0;

    // single-chunk message
    lit[0] = 16'hF5AF;
    run_msg(1, 16'h0AFB, 1'b0, 1'b1, 0, 1'b0);
    chk_lits(1, "single");

    // reset abort after two chunks, then a fresh message
    run_msg(4, 16'h0AFB, 1'b0, 1'b1, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_msg(4, 16'h0AFB, 1'b0, 1'b1, 0, 1'b0);
    chk_lits(4, "after_abort");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
